// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, default datapath width and the
// legality check used by both the result mux and the result stage.
package alu_pkg;

    // Default result datapath width
    localparam int ALU_DATA_W = 32;

    // Legal ALU select codes, named by operation
    localparam logic [3:0] ALU_SEL_ADD = 4'b0000;
    localparam logic [3:0] ALU_SEL_SUB = 4'b0001;
    localparam logic [3:0] ALU_SEL_AND = 4'b0010;
    localparam logic [3:0] ALU_SEL_OR  = 4'b0101;
    localparam logic [3:0] ALU_SEL_XOR = 4'b0110;
    localparam logic [3:0] ALU_SEL_SLL = 4'b0111;
    localparam logic [3:0] ALU_SEL_SRL = 4'b1000;
    localparam logic [3:0] ALU_SEL_SRA = 4'b1001;
    localparam logic [3:0] ALU_SEL_SLT = 4'b1011;

    // Status flags stored alongside every buffered result
    typedef struct packed {
        logic illegal;
        logic neg;
        logic zero;
    } alu_flags_t;

    // Returns 1 when sel is one of the nine codes the mux implements
    function automatic logic is_legal_select(input logic [3:0] sel);
        logic legal_s;
        case (sel)
            ALU_SEL_ADD, ALU_SEL_SUB, ALU_SEL_AND,
            ALU_SEL_OR,  ALU_SEL_XOR, ALU_SEL_SLL,
            ALU_SEL_SRL, ALU_SEL_SRA, ALU_SEL_SLT: legal_s = 1'b1;
            default:                                legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry circular FIFO with valid/ready handshake. All outputs are
// registered: in_ready and out_valid are derived from the next occupancy,
// and the head data is captured into its own register so it holds its
// last value once the buffer drains.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 39,
    parameter int DEPTH = 2   // pointers are 1 bit wide: only 2 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             push_s;
    logic             pop_s;

    // Next-state computation for storage, pointers, occupancy and outputs
    always_comb begin
        push_s   = in_valid_i && in_ready_q;
        pop_s    = out_valid_q && out_ready_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = ~wr_ptr_q;     // 1 -> 0 wrap
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;      // idle, or push+pop at occupancy 1
        endcase

        // Head follows the next read pointer; hold the last head when empty
        if (count_d != 2'd0) begin
            out_data_d = mem_d[rd_ptr_d];
        end else begin
            out_data_d = out_data_q;
        end

        out_valid_d = (count_d != 2'd0);
        in_ready_d  = (count_d < DEPTH_C);
    end

    // State registers; reset discards all entries asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux. Classifies each
// incoming select code, computes zero/negative flags at push time,
// sanitises illegal results to zero, counts illegal pushes and buffers
// entries in a two-entry FIFO so a stalled consumer loses nothing.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEPTH  = 2,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_select,
    input  logic [DATA_W-1:0] in_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_select,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_illegal,
    output logic [ERR_W-1:0]  err_count
);

    localparam int         ENTRY_W = DATA_W + 4 + 3;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic               legal_s;
    logic [DATA_W-1:0]  store_result_s;
    alu_flags_t         in_flags_s;
    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] out_entry_s;
    alu_flags_t         out_flags_s;
    logic               fifo_ready_s;
    logic               fifo_valid_s;
    logic               push_s;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    // Classify the incoming entry; illegal results never carry mux data
    always_comb begin
        legal_s = is_legal_select(in_select);
        if (legal_s) begin
            store_result_s     = in_result;
            in_flags_s.zero    = (in_result == {DATA_W{1'b0}});
            in_flags_s.neg     = in_result[DATA_W-1];
            in_flags_s.illegal = 1'b0;
        end else begin
            store_result_s     = {DATA_W{1'b0}};
            in_flags_s.zero    = 1'b0;
            in_flags_s.neg     = 1'b0;
            in_flags_s.illegal = 1'b1;
        end
        in_entry_s = {in_flags_s, in_select, store_result_s};
    end

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (fifo_ready_s),
        .in_data_i   (in_entry_s),
        .out_valid_o (fifo_valid_s),
        .out_ready_i (out_ready),
        .out_data_o  (out_entry_s)
    );

    // Saturating count of illegal entries actually accepted
    always_comb begin
        push_s = in_valid && fifo_ready_s;
        if (push_s && !legal_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Illegal-entry counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= {ERR_W{1'b0}};
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign out_flags_s = out_entry_s[ENTRY_W-1 -: 3];
    assign out_select  = out_entry_s[DATA_W +: 4];
    assign out_result  = out_entry_s[DATA_W-1:0];
    assign out_zero    = out_flags_s.zero;
    assign out_neg     = out_flags_s.neg;
    assign out_illegal = out_flags_s.illegal;
    assign out_valid   = fifo_valid_s;
    assign in_ready    = fifo_ready_s;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_select;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_select;
    logic        out_zero;
    logic        out_neg;
    logic        out_illegal;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    logic [38:0] sb_q[$];
    logic [38:0] last_head;
    int          err_model;
    logic [3:0]  legal_codes [9] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB};

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_select   (in_select),
        .in_result   (in_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_select  (out_select),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_illegal (out_illegal),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stored entry {illegal, neg, zero, select, result}
    function automatic logic [38:0] model_entry(input logic [3:0] sel, input logic [31:0] res);
        logic legal;
        legal = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (legal_codes[k] == sel) legal = 1'b1;
        end
        if (legal) return {1'b0, res[31], (res == 32'h0), sel, res};
        return {1'b1, 1'b0, 1'b0, sel, 32'h0};
    endfunction

    // One clock: check outputs at negedge, update scoreboard, advance past posedge
    task automatic step();
        logic [38:0] head;
        int          occ;
        @(negedge clk);
        occ  = sb_q.size();
        head = {out_illegal, out_neg, out_zero, out_select, out_result};
        chk("out_valid", out_valid, (occ != 0));
        chk("in_ready", in_ready, (occ < 2));
        chk("err_count", err_count, err_model);
        if (occ != 0) begin
            chk("head", head, sb_q[0]);
            if (out_ready) last_head = sb_q.pop_front();
        end else begin
            chk("hold_empty", head, last_head);
        end
        if (in_valid && occ < 2) begin
            sb_q.push_back(model_entry(in_select, in_result));
            if (model_entry(in_select, in_result) >> 38 != 0 && err_model < 255) err_model++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_select = 4'h0;
        in_result = 32'h0;
        out_ready = 1'b0;
        err_model = 0;
        last_head = 39'h0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_head", {out_illegal, out_neg, out_zero, out_select, out_result}, 39'h0);
        chk("rst_err", err_count, 8'h0);

        // Single legal op with zero result
        in_valid = 1'b1; in_select = 4'b0001; in_result = 32'h0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();

        // Illegal code carrying high-impedance data
        in_valid = 1'b1; in_select = 4'b0011; in_result = {32{1'bz}};
        step();
        in_valid = 1'b0; in_result = 32'h0;
        step();
        step();

        // Backpressure: fill both slots, hold, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_select = 4'b0101; in_result = 32'h8000_0001;
        step();
        in_select = 4'b0110; in_result = 32'h0000_0005;
        step();
        in_select = 4'b0010; in_result = 32'hDEAD_BEEF;  // refused while full
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        step();
        step();
        step();

        // Back-to-back stream with consumer always ready
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            in_select = legal_codes[$urandom_range(0, 8)];
            in_result = $urandom();
            if (n % 17 == 0) in_result = 32'h0;
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Saturation of the illegal-entry counter
        in_valid = 1'b1; in_select = 4'b1111;
        for (int n = 0; n < 300; n++) begin
            in_result = $urandom();
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("err_saturated", err_count, 8'd255);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0; in_valid = 1'b1; in_select = 4'b1000;
        in_result = 32'h1234_5678;
        step();
        in_result = 32'h8765_4321;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_err", err_count, 8'h0);
        sb_q.delete();
        err_model = 0;
        last_head = 39'h0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b1; in_select = 4'b1011; in_result = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
